// File: rtl/uart_tx_share_ctrl.sv
// uart_tx_share_ctrl
// Shares one 8N1 UART transmit pin between two byte-stream requesters.
// Arbitration happens per packet. The owner keeps the grant until it sends a
// byte marked LAST, or until it leaves VALID low for IDLE_TIMEOUT cycles.
// After either release, priority moves to the other requester.
//
// Ports
//   FAB_CCC_GL0        fabric clock (rising edge)
//   POWER_ON_RESET_N   async-assert, sync-deassert active-low reset
//   REQn_DATA/VALID/LAST  byte stream from requester n (LAST qualified by VALID)
//   REQn_READY         combinational accept strobe for requester n
//   TXD                serial output, idle high
//   GRANT              one-hot owner, 00 when unowned
//   BUSY               FSM not idle
//   TIMEOUT            one-cycle pulse when an idle owner loses its grant
module uart_tx_share_ctrl #(
  parameter int CLKS_PER_BIT = 434,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic       FAB_CCC_GL0,
  input  logic       POWER_ON_RESET_N,
  input  logic [7:0] REQ0_DATA,
  input  logic       REQ0_VALID,
  input  logic       REQ0_LAST,
  output logic       REQ0_READY,
  input  logic [7:0] REQ1_DATA,
  input  logic       REQ1_VALID,
  input  logic       REQ1_LAST,
  output logic       REQ1_READY,
  output logic       TXD,
  output logic [1:0] GRANT,
  output logic       BUSY,
  output logic       TIMEOUT
);

  localparam int              IW        = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [15:0]     BIT_END   = 16'(CLKS_PER_BIT - 1);
  // The last stop-bit cycle is spent in WAIT. An owner that already has its
  // next byte valid is then accepted there, so its start bit follows the
  // full-length stop bit with no gap.
  localparam logic [15:0]     STOP_HAND = 16'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0]   IDLE_END  = IW'(IDLE_TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT} state_t;

  // Reset synchroniser. Assertion is immediate, so TXD returns high at once.
  // Release is aligned to the clock.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge FAB_CCC_GL0 or negedge POWER_ON_RESET_N) begin
    if (!POWER_ON_RESET_N) rst_sync <= 2'b00;
    else                   rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t        state_q, state_d;
  logic [15:0]   baud_q;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [IW-1:0] idle_q;
  logic [7:0]    data_q;
  logic          last_q, owner_q, ptr_q, txd_q, timeout_q;
  logic [1:0]    grant_q, rdy;
  logic          accept, sel, txd_d, to_d, bit_end, own_valid;

  assign bit_end   = (baud_q == BIT_END);
  assign own_valid = owner_q ? REQ1_VALID : REQ0_VALID;

  always_ff @(posedge FAB_CCC_GL0 or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rdy       = 2'b00;
    accept    = 1'b0;
    sel       = owner_q;
    to_d      = 1'b0;
    bit_idx_d = bit_idx_q;
    case (state_q)
      S_IDLE: begin
        // READY stays low while the synchronised reset is still held.
        if (rst_n && (REQ0_VALID || REQ1_VALID)) begin
          sel     = REQ1_VALID && (!REQ0_VALID || ptr_q);
          accept  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: if (bit_end) begin
        state_d   = S_DATA;
        bit_idx_d = 3'd0;
      end
      S_DATA: if (bit_end) begin
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: begin
        if (last_q) begin
          if (bit_end) state_d = S_IDLE;
        end else if (baud_q == STOP_HAND) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // An accept on the final timeout cycle takes priority over the timeout.
        if (own_valid) begin
          accept  = 1'b1;
          state_d = S_START;
        end else if (idle_q == IDLE_END) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) rdy[sel] = 1'b1;
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = data_q[bit_idx_d];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge FAB_CCC_GL0 or negedge rst_n) begin
    if (!rst_n) begin
      baud_q    <= '0;
      bit_idx_q <= '0;
      idle_q    <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      owner_q   <= 1'b0;
      ptr_q     <= 1'b0;
      grant_q   <= 2'b00;
      txd_q     <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      txd_q     <= txd_d;
      timeout_q <= to_d;
      bit_idx_q <= bit_idx_d;
      if (state_d != state_q || bit_end || state_q == S_IDLE || state_q == S_WAIT)
        baud_q <= '0;
      else
        baud_q <= baud_q + 16'd1;
      idle_q <= (state_q == S_WAIT && state_d == S_WAIT) ? idle_q + IW'(1) : '0;
      if (accept) begin
        data_q  <= sel ? REQ1_DATA : REQ0_DATA;
        last_q  <= sel ? REQ1_LAST : REQ0_LAST;
        owner_q <= sel;
        grant_q <= sel ? 2'b10 : 2'b01;
      end else if (state_d == S_IDLE && state_q != S_IDLE) begin
        grant_q <= 2'b00;
        ptr_q   <= ~owner_q;
      end
    end
  end

  assign REQ0_READY = rdy[0];
  assign REQ1_READY = rdy[1];
  assign TXD        = txd_q;
  assign GRANT      = grant_q;
  assign BUSY       = (state_q != S_IDLE);
  assign TIMEOUT    = timeout_q;

endmodule

// File: tb/tb_uart_tx_share_ctrl.sv
// Directed bench for uart_tx_share_ctrl with CLKS_PER_BIT=4 and IDLE_TIMEOUT=8.
// Inputs change 1 ns after a rising edge. Outputs are sampled on the falling edge.
module tb_uart_tx_share_ctrl;
  localparam int CPB = 4;
  localparam int ITO = 8;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] REQ0_DATA = '0, REQ1_DATA = '0;
  logic       REQ0_VALID = 1'b0, REQ0_LAST = 1'b0, REQ1_VALID = 1'b0, REQ1_LAST = 1'b0;
  logic       REQ0_READY, REQ1_READY, TXD, BUSY, TIMEOUT;
  logic [1:0] GRANT;
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  uart_tx_share_ctrl #(.CLKS_PER_BIT(CPB), .IDLE_TIMEOUT(ITO)) dut (
    .FAB_CCC_GL0(clk), .POWER_ON_RESET_N(rst_n),
    .REQ0_DATA(REQ0_DATA), .REQ0_VALID(REQ0_VALID), .REQ0_LAST(REQ0_LAST), .REQ0_READY(REQ0_READY),
    .REQ1_DATA(REQ1_DATA), .REQ1_VALID(REQ1_VALID), .REQ1_LAST(REQ1_LAST), .REQ1_READY(REQ1_READY),
    .TXD(TXD), .GRANT(GRANT), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  typedef struct {
    logic v0; logic [7:0] d0; logic l0;
    logic v1; logic [7:0] d1; logic l1;
    logic [1:0] g; logic [7:0] b; int gap;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) chk("ready overlap", 32'(REQ0_READY & REQ1_READY), 32'd0);

  task automatic drive(input vec_t v);
    REQ0_VALID = v.v0; REQ0_DATA = v.d0; REQ0_LAST = v.l0;
    REQ1_VALID = v.v1; REQ1_DATA = v.d1; REQ1_LAST = v.l1;
  endtask

  // Call at a falling edge. Waits for a handshake and checks which READY fired
  // and the number of extra cycles waited (gap < 0 means the gap is not checked).
  // Returns 1 ns after the accepting rising edge.
  task automatic wait_hs(input string name, input logic [1:0] g, input int gap);
    int k;
    k = 0;
    while (!((REQ0_READY && REQ0_VALID) || (REQ1_READY && REQ1_VALID)) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({name, " ready"}, 32'({REQ1_READY, REQ0_READY}), 32'(g));
    if (gap >= 0) chk({name, " gap"}, 32'(k), 32'(gap));
    @(posedge clk); #1;
  endtask

  // Checks every cycle of one 10-bit frame that starts in the current cycle.
  task automatic frame_check(input string name, input logic [7:0] b, input logic [1:0] g);
    logic [9:0] fr, got;
    int bad_t, bad_g, bad_r, bad_o;
    fr = {1'b1, b, 1'b0};
    got = '0; bad_t = 0; bad_g = 0; bad_r = 0; bad_o = 0;
    for (int j = 0; j < 10*CPB; j++) begin
      @(negedge clk);
      if (TXD !== fr[j/CPB]) bad_t++;
      if (j % CPB == CPB/2) got[j/CPB] = TXD;
      if (GRANT !== g) bad_g++;
      if (j < 10*CPB-1 && (REQ0_READY || REQ1_READY)) bad_r++;
      if (TIMEOUT !== 1'b0 || BUSY !== 1'b1) bad_o++;
    end
    chk({name, " frame"}, 32'(got), 32'(fr));
    chk({name, " txd bad cycles"}, 32'(bad_t), 32'd0);
    chk({name, " grant bad cycles"}, 32'(bad_g), 32'd0);
    chk({name, " ready bad cycles"}, 32'(bad_r), 32'd0);
    chk({name, " busy/timeout bad cycles"}, 32'(bad_o), 32'd0);
  endtask

  initial begin
    int bad;
    tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 2'b01, 8'h11, -1};
    tbl[1] = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 2'b10, 8'h22, 1};
    tbl[2] = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 2'b01, 8'h11, 1};
    tbl[3] = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h01, 1'b0, 2'b10, 8'h01, 1};
    tbl[4] = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h02, 1'b0, 2'b10, 8'h02, 0};
    tbl[5] = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h03, 1'b1, 2'b10, 8'h03, 0};
    tbl[6] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 8'h11, 1};

    // Reset values, with both requesters valid.
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset txd", 32'(TXD), 32'd1);
    chk("reset ready", 32'({REQ1_READY, REQ0_READY}), 32'd0);
    chk("reset grant", 32'(GRANT), 32'd0);
    chk("reset busy", 32'(BUSY), 32'd0);
    chk("reset timeout", 32'(TIMEOUT), 32'd0);

    // Single REQ0 byte 0xA5.
    REQ1_VALID = 1'b0; REQ0_DATA = 8'hA5; REQ0_LAST = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    wait_hs("t1 hs", 2'b01, -1);
    REQ0_VALID = 1'b0;
    frame_check("t1 A5", 8'hA5, 2'b01);
    @(negedge clk);
    chk("t1 grant released", 32'(GRANT), 32'd0);
    chk("t1 busy released", 32'(BUSY), 32'd0);
    @(posedge clk); #1 drive(tbl[0]);
    @(negedge clk);
    chk("t1 pointer moved", 32'({REQ1_READY, REQ0_READY}), 32'b10);
    #1 rst_n = 1'b0;

    // Alternating single-byte packets, then a 3-byte REQ1 packet with REQ0 waiting.
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      wait_hs($sformatf("v%0d hs", i), tbl[i].g, tbl[i].gap);
      if (i < 6) drive(tbl[i+1]);
      else drive('{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 8'h00, 0});
      frame_check($sformatf("v%0d", i), tbl[i].b, tbl[i].g);
    end

    // Idle timeout with REQ1 pending.
    REQ0_VALID = 1'b1; REQ0_DATA = 8'h55; REQ0_LAST = 1'b0;
    @(negedge clk);
    wait_hs("t4 hs", 2'b01, -1);
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b1; REQ1_DATA = 8'h33; REQ1_LAST = 1'b1;
    frame_check("t4 55", 8'h55, 2'b01);
    bad = 0;
    repeat (ITO) begin
      @(negedge clk);
      if (GRANT !== 2'b01 || TIMEOUT !== 1'b0 || REQ1_READY !== 1'b0) bad++;
    end
    chk("t4 hold cycles bad", 32'(bad), 32'd0);
    @(negedge clk);
    chk("t4 grant revoked", 32'(GRANT), 32'd0);
    chk("t4 timeout pulse", 32'(TIMEOUT), 32'd1);
    wait_hs("t4 pending", 2'b10, 0);
    REQ1_VALID = 1'b0;
    frame_check("t4 33", 8'h33, 2'b10);

    // Owner VALID on the exact timeout cycle.
    REQ0_VALID = 1'b1; REQ0_DATA = 8'h5A; REQ0_LAST = 1'b0;
    @(negedge clk);
    wait_hs("t5 hs", 2'b01, 0);
    REQ0_VALID = 1'b0;
    frame_check("t5 5A", 8'h5A, 2'b01);
    bad = 0;
    repeat (ITO-1) begin
      @(negedge clk);
      if (GRANT !== 2'b01 || TIMEOUT !== 1'b0) bad++;
    end
    chk("t5 hold cycles bad", 32'(bad), 32'd0);
    @(posedge clk); #1;
    REQ0_VALID = 1'b1; REQ0_DATA = 8'hC3; REQ0_LAST = 1'b1;
    @(negedge clk);
    chk("t5 no timeout", 32'(TIMEOUT), 32'd0);
    wait_hs("t5 edge", 2'b01, 0);
    REQ0_VALID = 1'b0;
    frame_check("t5 C3", 8'hC3, 2'b01);

    // Reset during data bit 4 of 0xEF (bit 4 is 0).
    REQ0_VALID = 1'b1; REQ0_DATA = 8'hEF; REQ0_LAST = 1'b1;
    @(negedge clk);
    wait_hs("t6 hs", 2'b01, 0);
    repeat (22) @(negedge clk);
    chk("t6 bit4 low", 32'(TXD), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async txd", 32'(TXD), 32'd1);
    chk("t6 async ready", 32'({REQ1_READY, REQ0_READY}), 32'd0);
    chk("t6 async grant", 32'(GRANT), 32'd0);
    chk("t6 async busy", 32'(BUSY), 32'd0);
    repeat (2) @(negedge clk);
    chk("t6 ready in reset", 32'({REQ1_READY, REQ0_READY}), 32'd0);
    REQ0_DATA = 8'h3C;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    wait_hs("t6 fresh", 2'b01, -1);
    REQ0_VALID = 1'b0;
    frame_check("t6 3C", 8'h3C, 2'b01);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
